ssidft_tidx: RTL and testbench

//  Single-sample inverse DFT at a run-time selectable time index n: from one

---
 rtl/ssidft_pkg.sv | 46 ++++
 rtl/ssidft_twiddle_rom.sv | 27 ++
 rtl/ssidft_tidx.sv | 135 +++++++++++++
 tb/tb_ssidft_tidx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssidft_pkg.sv
// Shared types and helpers for the run-time indexed single-sample inverse DFT.
package ssidft_pkg;

  typedef enum logic {IDLE, ACTIVE} frame_state_e;

  localparam int RSW = 128;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } round_sat_t;

  // round(cos(2*pi*idx/n) * (2^(tw-1)-1)), ties away from zero
  function automatic int twiddle_val(input int idx, input int n, input int tw);
    real scale;
    real v;
    scale = (2.0 ** (tw - 1)) - 1.0;
    v = $cos(2.0 * 3.14159265358979323846 * real'(idx) / real'(n)) * scale;
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Round half up after an arithmetic right shift, then clip to ow signed bits
  function automatic round_sat_t round_sat(input logic signed [RSW-1:0] acc,
                                           input int shift, input int ow);
    logic signed [RSW-1:0] one;
    logic signed [RSW-1:0] r;
    logic signed [RSW-1:0] hi;
    logic signed [RSW-1:0] lo;
    round_sat_t res;
    one = RSW'(1);
    r   = (acc + (one <<< (shift - 1))) >>> shift;
    hi  = (one <<< (ow - 1)) - one;
    lo  = -(one <<< (ow - 1));
    res.ovf = 1'b0;
    res.val = r[63:0];
    if (r > hi) begin
      res.ovf = 1'b1;
      res.val = hi[63:0];
    end else if (r < lo) begin
      res.ovf = 1'b1;
      res.val = lo[63:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ssidft_twiddle_rom.sv
// Dual-read cosine table; sine is read through the second port at a quarter-turn offset.
module ssidft_twiddle_rom
  import ssidft_pkg::*;
#(
  parameter int N  = 4096,
  parameter int AW = $clog2(N),
  parameter int TW = 16
) (
  input  logic                 clk_i,
  input  logic [AW-1:0]        addr_a,
  input  logic [AW-1:0]        addr_b,
  output logic signed [TW-1:0] data_a,
  output logic signed [TW-1:0] data_b
);

  logic signed [TW-1:0] cos_tab [N];

  for (genvar i = 0; i < N; i++) begin : g_tab
    assign cos_tab[i] = TW'(twiddle_val(i, N, TW));
  end

  always_ff @(posedge clk_i) begin
    data_a <= cos_tab[addr_a];
    data_b <= cos_tab[addr_b];
  end

endmodule

// File: rtl/ssidft_tidx.sv
// Single-sample inverse DFT: x[n] = (1/N) * sum Re(X[k] * e^{+j2*pi*k*n/N}) at a per-frame index n.
module ssidft_tidx
  import ssidft_pkg::*;
#(
  parameter int DW = 16,
  parameter int OW = 16,
  parameter int N  = 4096,
  parameter int AW = $clog2(N),
  parameter int TW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sob_i,
  input  logic                 eob_i,
  input  logic                 bin_valid_i,
  input  logic [AW-1:0]        tidx_i,
  input  logic signed [DW-1:0] freq_re_i,
  input  logic signed [DW-1:0] freq_im_i,
  output logic signed [OW-1:0] sample_o,
  output logic                 sample_en_o,
  output logic                 ovf_o,
  output logic                 frame_err_o
);

  localparam int ACCW  = DW + TW + AW + 1;
  localparam int SHIFT = TW - 1 + AW;
  localparam logic [AW-1:0] QUARTER  = AW'(N / 4);
  localparam logic [AW-1:0] LAST_CNT = AW'(N - 1);

  frame_state_e state;
  logic [AW-1:0] bin_cnt, phase, tidx_q;
  logic          start, cont, abort, accept, err_now;
  logic [AW-1:0] beat_ph, step;

  // A sob beat always opens a frame; other beats only count inside an open frame
  always_comb begin
    start   = bin_valid_i & sob_i;
    cont    = bin_valid_i & ~sob_i & (state == ACTIVE);
    abort   = cont & ~eob_i & (bin_cnt == LAST_CNT);
    accept  = start | cont;
    err_now = (start & (state == ACTIVE))
            | (bin_valid_i & ~sob_i & (state == IDLE))
            | abort;
    beat_ph = start ? '0 : phase;
    step    = start ? tidx_i : tidx_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bin_cnt     <= '0;
      phase       <= '0;
      tidx_q      <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= err_now;
      if (accept) phase <= beat_ph + step;
      if (start) begin
        tidx_q  <= tidx_i;
        bin_cnt <= AW'(1);
        state   <= eob_i ? IDLE : ACTIVE;
      end else if (cont) begin
        bin_cnt <= bin_cnt + AW'(1);
        if (eob_i || abort) state <= IDLE;
      end
    end
  end

  logic signed [TW-1:0] cos_v, sin_v;

  ssidft_twiddle_rom #(.N(N), .AW(AW), .TW(TW)) u_rom (
    .clk_i  (clk_i),
    .addr_a (beat_ph),
    .addr_b (beat_ph - QUARTER),
    .data_a (cos_v),
    .data_b (sin_v)
  );

  logic                    v1, first1, last1, v2, first2, last2, done3;
  logic signed [DW-1:0]    re1, im1;
  logic signed [DW+TW-1:0] prod_c, prod_s;
  logic signed [ACCW-1:0]  acc, diff;

  assign diff = ACCW'(prod_c) - ACCW'(prod_s);

  // Bin data rides alongside the ROM read so it meets its twiddles one stage later
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      re1    <= '0;
      im1    <= '0;
      v2     <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      prod_c <= '0;
      prod_s <= '0;
      acc    <= '0;
      done3  <= 1'b0;
    end else begin
      v1     <= accept;
      first1 <= start;
      last1  <= accept & eob_i;
      re1    <= freq_re_i;
      im1    <= freq_im_i;
      v2     <= v1;
      first2 <= v1 & first1;
      last2  <= v1 & last1;
      prod_c <= re1 * cos_v;
      prod_s <= im1 * sin_v;
      if (v2) acc <= first2 ? diff : acc + diff;
      done3  <= v2 & last2;
    end
  end

  round_sat_t rs;

  always_comb rs = round_sat(RSW'(acc), SHIFT, OW);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_o    <= '0;
      sample_en_o <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      sample_en_o <= done3;
      if (done3) begin
        sample_o <= rs.val[OW-1:0];
        ovf_o    <= rs.ovf;
      end
    end
  end

endmodule

// File: tb/tb_ssidft_tidx.sv
// Directed bench for ssidft_tidx at N=16: a 16-bit and an 8-bit output instance share one stimulus.
module tb_ssidft_tidx;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TW = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 sob_i = 1'b0;
  logic                 eob_i = 1'b0;
  logic                 bin_valid_i = 1'b0;
  logic [AW-1:0]        tidx_i = '0;
  logic signed [DW-1:0] freq_re_i = '0;
  logic signed [DW-1:0] freq_im_i = '0;
  logic signed [15:0]   sample_o;
  logic                 sample_en_o, ovf_o, frame_err_o;
  logic signed [7:0]    sample8;
  logic                 sample_en8, ovf8, frame_err8;

  ssidft_tidx #(.DW(DW), .OW(16), .N(N), .AW(AW), .TW(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sob_i(sob_i), .eob_i(eob_i),
    .bin_valid_i(bin_valid_i), .tidx_i(tidx_i),
    .freq_re_i(freq_re_i), .freq_im_i(freq_im_i),
    .sample_o(sample_o), .sample_en_o(sample_en_o),
    .ovf_o(ovf_o), .frame_err_o(frame_err_o)
  );

  ssidft_tidx #(.DW(DW), .OW(8), .N(N), .AW(AW), .TW(TW)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .sob_i(sob_i), .eob_i(eob_i),
    .bin_valid_i(bin_valid_i), .tidx_i(tidx_i),
    .freq_re_i(freq_re_i), .freq_im_i(freq_im_i),
    .sample_o(sample8), .sample_en_o(sample_en8),
    .ovf_o(ovf8), .frame_err_o(frame_err8)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int s;
    int o;
    int s8;
    int o8;
    int cyc;
  } samp_t;

  typedef struct {
    string name;
    int    pattern;
    int    n;
    int    nbins;
    int    exp;
    int    ovf;
    int    exp8;
    int    ovf8;
  } vec_t;

  samp_t sq[$];
  int    cyc = 0;
  int    err_cnt = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    bre[N];
  int    bim[N];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every output pulse with the cycle it appeared in
  always @(negedge clk_i) begin
    samp_t e;
    if (sample_en_o) begin
      e.s   = int'(sample_o);
      e.o   = int'(ovf_o);
      e.s8  = int'(sample8);
      e.o8  = int'(ovf8);
      e.cyc = cyc;
      sq.push_back(e);
    end
    if (frame_err_o) err_cnt++;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void setBins(input int pattern);
    for (int k = 0; k < N; k++) begin
      bre[k] = 0;
      bim[k] = 0;
      if (pattern == 0) bre[k] = 1000;
      if (pattern == 3) bre[k] = -1000;
    end
    if (pattern == 1) bre[1] = 1600;
    if (pattern == 2) bim[1] = 1600;
    if (pattern == 4) bre[4] = 800;
  endfunction

  task automatic driveBeat(input logic sob, input logic eob, input int re, input int im,
                           input logic [AW-1:0] n);
    bin_valid_i = 1'b1;
    sob_i       = sob;
    eob_i       = eob;
    freq_re_i   = DW'(re);
    freq_im_i   = DW'(im);
    tidx_i      = n;
    @(posedge clk_i);
    #1;
  endtask

  // Noisy idles toggle sob/eob and data with bin_valid low; all of it must be ignored
  task automatic idleCycles(input int cnt, input bit noisy);
    for (int i = 0; i < cnt; i++) begin
      bin_valid_i = 1'b0;
      sob_i       = noisy ? 1'($urandom) : 1'b0;
      eob_i       = noisy ? 1'($urandom) : 1'b0;
      freq_re_i   = noisy ? DW'($urandom) : '0;
      freq_im_i   = noisy ? DW'($urandom) : '0;
      tidx_i      = noisy ? AW'($urandom) : '0;
      @(posedge clk_i);
      #1;
    end
    sob_i = 1'b0;
    eob_i = 1'b0;
  endtask

  task automatic sendFrame(input int n, input int nbins, input bit with_eob, input bit gaps,
                           output int eob_cyc);
    eob_cyc = -1;
    for (int k = 0; k < nbins; k++) begin
      if (gaps && k > 0) idleCycles($urandom_range(0, 2), 1'b1);
      if (with_eob && k == nbins - 1) eob_cyc = cyc;
      driveBeat(k == 0, with_eob && (k == nbins - 1), bre[k], bim[k],
                (k == 0) ? AW'(n) : AW'($urandom));
    end
    bin_valid_i = 1'b0;
    sob_i       = 1'b0;
    eob_i       = 1'b0;
  endtask

  task automatic checkFrame(input string name, input int exp, input int ovf,
                            input int exp8, input int ovf8, input int eob_cyc);
    samp_t e;
    checkOutput({name, "_count"}, sq.size(), 1);
    if (sq.size() > 0) begin
      e = sq.pop_front();
      checkOutput({name, "_sample"}, e.s, exp);
      checkOutput({name, "_ovf"}, e.o, ovf);
      checkOutput({name, "_sample8"}, e.s8, exp8);
      checkOutput({name, "_ovf8"}, e.o8, ovf8);
      checkOutput({name, "_latency"}, e.cyc - eob_cyc, 4);
    end
    sq.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    int ec;
    int e0;
    setBins(v.pattern);
    e0 = err_cnt;
    sendFrame(v.n, v.nbins, 1'b1, 1'b0, ec);
    idleCycles(10, 1'b0);
    checkFrame(v.name, v.exp, v.ovf, v.exp8, v.ovf8, ec);
    checkOutput({v.name, "_err"}, err_cnt - e0, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int    ec;
    int    ec2;
    int    e0;
    samp_t e;

    vecs[0] = '{"t1_dc_n0",  0, 0, 16,  1000, 0,  127, 1};
    vecs[1] = '{"t2_x1_n0",  1, 0, 16,   100, 0,  100, 0};
    vecs[2] = '{"t2_x1_n4",  1, 4, 16,     0, 0,    0, 0};
    vecs[3] = '{"t2_x1_n8",  1, 8, 16,  -100, 0, -100, 0};
    vecs[4] = '{"t3_im_n4",  2, 4, 16,  -100, 0, -100, 0};
    vecs[5] = '{"dc_n8",     0, 8, 16,     0, 0,    0, 0};
    vecs[6] = '{"im_n0",     2, 0, 16,     0, 0,    0, 0};
    vecs[7] = '{"neg_dc_n0", 3, 0, 16, -1000, 0, -128, 1};
    vecs[8] = '{"x4_n2",     4, 2, 16,   -50, 0,  -50, 0};
    vecs[9] = '{"short8_n8", 1, 8,  8,  -100, 0, -100, 0};

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_sample", int'(sample_o), 0);
    checkOutput("rst_sample_en", int'(sample_en_o), 0);
    checkOutput("rst_ovf", int'(ovf_o), 0);
    checkOutput("rst_frame_err", int'(frame_err_o), 0);
    rst_i = 1'b0;
    idleCycles(2, 1'b0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] gapped frame");
    setBins(1);
    e0 = err_cnt;
    sendFrame(8, 16, 1'b1, 1'b1, ec);
    idleCycles(10, 1'b0);
    checkFrame("gaps", -100, 0, -100, 0, ec);
    checkOutput("gaps_err", err_cnt - e0, 0);

    $display("[TB] sob inside an open frame");
    setBins(0);
    e0 = err_cnt;
    sendFrame(0, 5, 1'b0, 1'b0, ec);
    setBins(1);
    sendFrame(8, 16, 1'b1, 1'b0, ec);
    idleCycles(10, 1'b0);
    checkFrame("restart", -100, 0, -100, 0, ec);
    checkOutput("restart_err", err_cnt - e0, 1);

    $display("[TB] one-bin frame");
    e0 = err_cnt;
    ec = cyc;
    driveBeat(1'b1, 1'b1, 16000, 0, AW'(5));
    idleCycles(10, 1'b0);
    checkFrame("one_bin", 1000, 0, 127, 1, ec);
    checkOutput("one_bin_err", err_cnt - e0, 0);

    $display("[TB] beat while no frame is open");
    e0 = err_cnt;
    driveBeat(1'b0, 1'b1, 500, 0, AW'(0));
    idleCycles(10, 1'b0);
    checkOutput("stray_count", sq.size(), 0);
    checkOutput("stray_err", err_cnt - e0, 1);
    sq.delete();

    $display("[TB] frame of N beats without eob");
    setBins(0);
    e0 = err_cnt;
    sendFrame(0, 16, 1'b0, 1'b0, ec);
    driveBeat(1'b0, 1'b1, 1000, 0, AW'(0));
    idleCycles(10, 1'b0);
    checkOutput("abort_count", sq.size(), 0);
    checkOutput("abort_err", err_cnt - e0, 2);
    sq.delete();

    $display("[TB] back-to-back frames");
    setBins(1);
    sendFrame(0, 16, 1'b1, 1'b0, ec);
    sendFrame(8, 16, 1'b1, 1'b0, ec2);
    idleCycles(10, 1'b0);
    checkOutput("b2b_count", sq.size(), 2);
    if (sq.size() == 2) begin
      e = sq.pop_front();
      checkOutput("b2b_first", e.s, 100);
      checkOutput("b2b_first_latency", e.cyc - ec, 4);
      e = sq.pop_front();
      checkOutput("b2b_second", e.s, -100);
      checkOutput("b2b_second_latency", e.cyc - ec2, 4);
    end
    sq.delete();

    $display("[TB] reset in the middle of a frame");
    setBins(0);
    e0 = err_cnt;
    sendFrame(0, 7, 1'b0, 1'b0, ec);
    rst_i = 1'b1;
    driveBeat(1'b0, 1'b1, bre[7], bim[7], AW'(0));
    bin_valid_i = 1'b0;
    eob_i       = 1'b0;
    checkOutput("midrst_sample", int'(sample_o), 0);
    checkOutput("midrst_ovf", int'(ovf_o), 0);
    rst_i = 1'b0;
    idleCycles(10, 1'b0);
    checkOutput("midrst_count", sq.size(), 0);
    checkOutput("midrst_err", err_cnt - e0, 0);
    sq.delete();
    applyStimulus(vecs[0]);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
